// File: rtl/bit4_pkg.sv
// Shared constants and types for the cascadable down counter.
package bit4_pkg;
  localparam int BIT4_WIDTH = 4;
  localparam logic [BIT4_WIDTH-1:0] BIT4_ALL_ONES = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_WRAP
  } cnt_state_e;
endpackage

// File: rtl/bit4_decrementer.sv
// Combinational ripple-borrow decrementer: S = A - Bin, Bout = Bin & (A == 0).
module bit4_decrementer import bit4_pkg::*; #(
  parameter int WIDTH = BIT4_WIDTH
) (
  input  logic [WIDTH-1:0] A,
  input  logic             Bin,
  output logic [WIDTH-1:0] S,
  output logic             Bout
);
  logic [WIDTH:0] brw;

  assign brw[0] = Bin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign S[i]     = A[i] ^ brw[i];
    assign brw[i+1] = brw[i] & ~A[i];
  end

  assign Bout = brw[WIDTH];
endmodule

// File: rtl/bit4_down_counter.sv
// Cascadable down counter with parallel load and sticky underflow flag.
// Define BIT4_DOWN_COUNTER_RELOAD_EN to reload Q from D on underflow instead of wrapping.
module bit4_down_counter import bit4_pkg::*; #(
  parameter int WIDTH = BIT4_WIDTH
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  input  logic             EN,
  input  logic             Bin,
  input  logic             CLR_UF,
  output logic [WIDTH-1:0] Q,
  output logic             Bout,
  output logic             ZERO,
  output logic             UF
);
  logic             dec;
  logic             uflow;
  logic [WIDTH-1:0] q_dec;
  logic [WIDTH-1:0] q_nxt;
  cnt_state_e       state_q, state_d;

  // Feeding the decrement enable in as borrow-in makes q_dec equal Q when idle
  // and the decrementer's borrow-out exactly the underflow / cascade borrow.
  assign dec = ~LOAD & EN & Bin;

  bit4_decrementer #(.WIDTH(WIDTH)) u_dec (
    .A    (Q),
    .Bin  (dec),
    .S    (q_dec),
    .Bout (uflow)
  );

  assign Bout = uflow;
  assign ZERO = (Q == '0);

  always_comb begin
    q_nxt = q_dec;
    if (LOAD) q_nxt = D;
`ifdef BIT4_DOWN_COUNTER_RELOAD_EN
    else if (uflow) q_nxt = D;
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (LOAD && (D != '0)) state_d = ST_RUN;
      ST_RUN:  if (uflow) state_d = ST_WRAP;
      ST_WRAP: state_d = EN ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      Q       <= '0;
      UF      <= 1'b0;
      state_q <= ST_IDLE;
    end else begin
      Q       <= q_nxt;
      // a same-edge underflow beats any clear
      UF      <= uflow | (UF & ~(CLR_UF | LOAD));
      state_q <= state_d;
    end
  end
endmodule

// File: doc/bit4_down_counter.md
BIT4_DOWN_COUNTER -- requirements
Module: bit4_down_counter

Interface
REQ-001 Parameter WIDTH, default 4, sets the count width in bits; all behaviour below is specified at WIDTH=4.
REQ-002 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-003 RSTN  input  1  reset; synchronous and active-low.
REQ-004 LOAD  input  1  parallel-load request, highest priority after reset.
REQ-005 D  input  4  parallel-load value.
REQ-006 EN  input  1  count enable.
REQ-007 Bin  input  1  borrow-in from the lower cascaded stage; tie to 1 for a standalone stage.
REQ-008 CLR_UF  input  1  clears the sticky underflow flag.
REQ-009 Q  output  4  registered count value.
REQ-010 Bout  output  1  borrow-out to the next stage (combinational).
REQ-011 ZERO  output  1  high while Q==0 (combinational from the Q register).
REQ-012 UF  output  1  sticky underflow flag (registered).

Function
REQ-013 Each cycle is resolved by priority: reset, LOAD, decrement, hold.
REQ-014 LOAD=1: Q takes D on the next edge, regardless of EN or Bin.
REQ-015 LOAD=0, EN=1, Bin=1: Q takes Q-1 on the next edge (decrement).
REQ-016 Any other input combination: Q holds its value.
REQ-017 Decrement latency is one cycle; Q changes only on clock edges.
REQ-018 Bout = EN & Bin & (Q==0) & ~LOAD.
REQ-019 Bout carries no register stage, so N cascaded stages behave as one 4N-bit down counter.
REQ-020 A decrement from Q==0 is an underflow.
REQ-021 On underflow, UF is set on the same edge on which Q changes.
REQ-022 Arithmetic is modulo 2^WIDTH, computed with a ripple-borrow chain.
REQ-023 UF clears on CLR_UF=1 or on LOAD=1.
REQ-024 If an underflow and a clear (CLR_UF or LOAD) occur on the same edge, the set wins.
REQ-025 An underflow and LOAD can never coincide, because LOAD blocks the decrement.
REQ-026 Internal FSM states: IDLE (Q==0, no count), RUN (count in progress), WRAP (one-cycle state after an underflow).
REQ-027 FSM transitions: IDLE->RUN on LOAD with D!=0; RUN->WRAP on underflow; WRAP->RUN on the next cycle if EN=1, otherwise WRAP->IDLE.
REQ-028 The FSM state is internal only and not exported.
REQ-029 The FSM never alters Q, which is governed solely by REQ-013 to REQ-016.

Reset
REQ-030 While RSTN=0 at a rising edge: Q=0, UF=0, FSM=IDLE.
REQ-031 While in reset, ZERO=1 and Bout follows REQ-018 with Q=0.
REQ-032 Reset asserted mid-count overrides LOAD and EN on that edge.
REQ-033 The first count after RSTN deasserts starts from 0 (underflow to 15, UF=1).

Configuration
REQ-034 Macro BIT4_DOWN_COUNTER_RELOAD_EN selects the underflow behaviour.
REQ-035 With the macro defined: an underflow loads Q with D instead of wrapping to 15 (auto-reload), and UF still sets.
REQ-036 Without the macro: an underflow wraps Q to 2^WIDTH-1; the reload logic is absent.

Structure
REQ-037 Package bit4_pkg holds the WIDTH default, the FSM state enum typedef and the all-ones constant.
REQ-038 Sub-module bit4_decrementer is combinational: A[3:0], Bin -> S[3:0], Bout, using a ripple borrow.
REQ-039 Counter registers, FSM and flags live in bit4_down_counter.

Verification
REQ-040 Scenario: RSTN=0 for 2 cycles, then released with EN=0 -> Q=0, ZERO=1, UF=0, Bout=0.
REQ-041 Scenario: LOAD with D=5, then EN=Bin=1 for 5 cycles -> Q=4,3,2,1,0; ZERO=1 at the end; Bout=1 on the cycle Q==0; UF=0.
REQ-042 Scenario: Q=0, EN=Bin=1 for one cycle, without the macro -> Q=15, UF=1. With the macro and D=9 -> Q=9, UF=1.
REQ-043 Scenario: UF=1, underflow with CLR_UF=1 on the same edge -> UF stays 1. A later CLR_UF alone -> UF=0.
REQ-044 Scenario: two stages cascaded (low Bout into high Bin), both loaded with 0x10 -> after one decrement the pair reads 0x0F; the high stage decrements only on the edge where the low stage underflows.
REQ-045 Scenario: RSTN=0 asserted with LOAD=1, D=7 at Q=3 -> Q=0, not 7.
